// File: rtl/banked_register_file.sv
// banked_register_file
//   Multi-bank register file. All read/write/PC ports act on active_bank.
//   Condition flags {zero, positive, negative} are kept per bank.
//   A sequential copy engine duplicates one bank into another, one
//   register per cycle, for context switching.
//
//   Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
//   data to the read and PC outputs. Without it, outputs come from storage
//   only.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   active_bank           bank used by read/write/PC ports
//   left/right_register_num, left/right_register_out   read ports (comb)
//   write_register_num, write_register_in, write_en    write port
//   pc_register_in, pc_write_en, pc_register_out       PC port
//   cond_bit_out          flags of the active bank
//   copy_start, copy_src, copy_dst                     copy request
//   copy_busy, copy_done  copy status
module banked_register_file #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter int NUM_BANKS = 2,
  parameter int PC_INDEX  = 6,
  localparam int RW = $clog2(NUM_REGS),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BW-1:0]     active_bank,
  input  logic [RW-1:0]     left_register_num,
  input  logic [RW-1:0]     right_register_num,
  output logic [DATA_W-1:0] left_register_out,
  output logic [DATA_W-1:0] right_register_out,
  input  logic [RW-1:0]     write_register_num,
  input  logic [DATA_W-1:0] write_register_in,
  input  logic              write_en,
  input  logic [DATA_W-1:0] pc_register_in,
  input  logic              pc_write_en,
  output logic [DATA_W-1:0] pc_register_out,
  output logic [2:0]        cond_bit_out,
  input  logic              copy_start,
  input  logic [BW-1:0]     copy_src,
  input  logic [BW-1:0]     copy_dst,
  output logic              copy_busy,
  output logic              copy_done
);

  localparam logic [RW-1:0] PC_IDX = RW'(PC_INDEX);
  localparam logic [RW-1:0] LAST   = RW'(NUM_REGS - 1);

  typedef enum logic {IDLE, COPY} state_t;

  logic [NUM_BANKS-1:0][NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_BANKS-1:0][2:0]                      flags;

  state_t        state, state_d;
  logic [RW-1:0] idx, idx_d;
  logic [BW-1:0] src_q, src_d, dst_q, dst_d;
  logic          done_q, done_d;

  function automatic logic [2:0] flags_of(input logic [DATA_W-1:0] d);
    logic z;
    z = (d == '0);
    return {z, ~d[DATA_W-1] & ~z, d[DATA_W-1]};
  endfunction

  // ---------------- copy FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      src_q  <= src_d;
      dst_q  <= dst_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    src_d   = src_q;
    dst_d   = dst_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (copy_start && (copy_src != copy_dst)) begin
          src_d   = copy_src;
          dst_d   = copy_dst;
          idx_d   = RW'(1);  // register 0 is hardwired zero, skip it
          state_d = COPY;
        end
      end
      COPY: begin
        idx_d = idx + RW'(1);
        if (idx == LAST) begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign copy_busy = (state == COPY);
  assign copy_done = done_q;

  // ---------------- storage ----------------
  // Later assignments win: copy write < core write < PC write. The copy
  // reads pre-edge values because all updates are non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs  <= '0;
      flags <= '0;
    end else begin
      if (state == COPY) begin
        regs[dst_q][idx] <= regs[src_q][idx];
        if (idx == LAST) flags[dst_q] <= flags[src_q];
      end
      if (write_en) begin
        if (write_register_num != '0)
          regs[active_bank][write_register_num] <= write_register_in;
        flags[active_bank] <= flags_of(write_register_in);
      end
      if (pc_write_en)
        regs[active_bank][PC_IDX] <= pc_register_in;
    end
  end

  // ---------------- read side ----------------
  logic [DATA_W-1:0] left_st, right_st, pc_st;

  // Register 0 never gets written, but gate it anyway so reads are 0 by
  // construction rather than by storage state.
  assign left_st  = (left_register_num  == '0) ? '0 : regs[active_bank][left_register_num];
  assign right_st = (right_register_num == '0) ? '0 : regs[active_bank][right_register_num];
  assign pc_st    = regs[active_bank][PC_IDX];

`ifdef REGFILE_BYPASS_EN
  assign left_register_out  = (write_en && write_register_num == left_register_num &&
                               left_register_num != '0) ? write_register_in : left_st;
  assign right_register_out = (write_en && write_register_num == right_register_num &&
                               right_register_num != '0) ? write_register_in : right_st;
  assign pc_register_out    = pc_write_en ? pc_register_in :
                              (write_en && write_register_num == PC_IDX) ? write_register_in :
                              pc_st;
`else
  assign left_register_out  = left_st;
  assign right_register_out = right_st;
  assign pc_register_out    = pc_st;
`endif

  // Flags are never forwarded.
  assign cond_bit_out = flags[active_bank];

endmodule

// File: tb/tb_banked_register_file.sv
module tb_banked_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  active_bank;
  logic [3:0]  left_register_num, right_register_num, write_register_num;
  logic [15:0] left_register_out, right_register_out;
  logic [15:0] write_register_in, pc_register_in, pc_register_out;
  logic        write_en, pc_write_en;
  logic [2:0]  cond_bit_out;
  logic        copy_start, copy_busy, copy_done;
  logic [0:0]  copy_src, copy_dst;

  banked_register_file dut (
    .clk(clk), .rst_n(rst_n), .active_bank(active_bank),
    .left_register_num(left_register_num), .right_register_num(right_register_num),
    .left_register_out(left_register_out), .right_register_out(right_register_out),
    .write_register_num(write_register_num), .write_register_in(write_register_in),
    .write_en(write_en), .pc_register_in(pc_register_in), .pc_write_en(pc_write_en),
    .pc_register_out(pc_register_out), .cond_bit_out(cond_bit_out),
    .copy_start(copy_start), .copy_src(copy_src), .copy_dst(copy_dst),
    .copy_busy(copy_busy), .copy_done(copy_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [15:0] model [2][16];
  logic [2:0]  mflag [2];
  int          errors = 0;
  int          checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      mflag[b] = 3'b000;
      for (int r = 0; r < 16; r++) model[b][r] = 16'h0;
    end
  endtask

  task automatic wr(input int b, input int r, input logic [15:0] d);
    active_bank        = 1'(b);
    write_register_num = 4'(r);
    write_register_in  = d;
    write_en           = 1'b1;
    tick();
    write_en = 1'b0;
    if (r != 0) model[b][r] = d;
    mflag[b] = {d == 16'h0, ~d[15] & (d != 16'h0), d[15]};
  endtask

  // Reads every register of every bank through both ports via the queue.
  task automatic read_all_banks(input string tag);
    for (int b = 0; b < 2; b++) begin
      active_bank = 1'(b);
      for (int r = 0; r < 16; r++) begin
        left_register_num  = 4'(r);
        right_register_num = 4'(15 - r);
        sbq.push_back('{$sformatf("%s_b%0d_left_r%0d", tag, b, r), model[b][r]});
        sbq.push_back('{$sformatf("%s_b%0d_right_r%0d", tag, b, 15 - r), model[b][15 - r]});
        #1;
        e = sbq.pop_front(); checks++;
        if (left_register_out !== e.exp) begin
          errors++; $display("FAIL %s got=%h exp=%h", e.name, left_register_out, e.exp);
        end
        e = sbq.pop_front(); checks++;
        if (right_register_out !== e.exp) begin
          errors++; $display("FAIL %s got=%h exp=%h", e.name, right_register_out, e.exp);
        end
      end
      sbq.push_back('{$sformatf("%s_b%0d_cond", tag, b), {13'h0, mflag[b]}});
      e = sbq.pop_front(); checks++;
      if ({13'h0, cond_bit_out} !== e.exp) begin
        errors++; $display("FAIL %s got=%b exp=%b", e.name, cond_bit_out, e.exp[2:0]);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    active_bank = '0; left_register_num = '0; right_register_num = '0;
    write_register_num = '0; write_register_in = '0; write_en = 1'b0;
    pc_register_in = '0; pc_write_en = 1'b0;
    copy_start = 1'b0; copy_src = '0; copy_dst = '0;
    model_clear();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (copy_busy !== 1'b0 || copy_done !== 1'b0) begin
      errors++; $display("FAIL reset_copy_status got=%b%b exp=00", copy_busy, copy_done);
    end
    checks++;
    if (pc_register_out !== 16'h0) begin
      errors++; $display("FAIL reset_pc got=%h exp=0000", pc_register_out);
    end
    read_all_banks("reset");
  endtask

  task automatic test_write();
    active_bank = 1'b0;
    left_register_num = 4'd3;
    write_register_num = 4'd3; write_register_in = 16'h8001; write_en = 1'b1;
`ifdef REGFILE_BYPASS_EN
    sbq.push_back('{"write_same_cycle", 16'h8001});
`else
    sbq.push_back('{"write_same_cycle", 16'h0000});
`endif
    #1;
    e = sbq.pop_front(); checks++;
    if (left_register_out !== e.exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", e.name, left_register_out, e.exp);
    end
    tick();
    write_en = 1'b0;
    model[0][3] = 16'h8001; mflag[0] = 3'b001;
    sbq.push_back('{"write_next_cycle", 16'h8001});
    sbq.push_back('{"write_cond", 16'h0001});
    e = sbq.pop_front(); checks++;
    if (left_register_out !== e.exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", e.name, left_register_out, e.exp);
    end
    e = sbq.pop_front(); checks++;
    if ({13'h0, cond_bit_out} !== e.exp) begin
      errors++; $display("FAIL %s got=%b exp=%b", e.name, cond_bit_out, e.exp[2:0]);
    end
  endtask

  task automatic test_r0_pc();
    wr(0, 0, 16'h0000);
    left_register_num = 4'd0;
    #1;
    checks++;
    if (left_register_out !== 16'h0) begin
      errors++; $display("FAIL r0_read got=%h exp=0000", left_register_out);
    end
    checks++;
    if (cond_bit_out !== 3'b100) begin
      errors++; $display("FAIL r0_cond got=%b exp=100", cond_bit_out);
    end
    // PC write and a core write to the PC register in the same cycle
    tick();
    pc_register_in = 16'h0100; pc_write_en = 1'b1;
    wr(0, 6, 16'h0200);
    pc_write_en = 1'b0;
    model[0][6] = 16'h0100;
    sbq.push_back('{"pc_wins", model[0][6]});
    e = sbq.pop_front(); checks++;
    if (pc_register_out !== e.exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", e.name, pc_register_out, e.exp);
    end
    checks++;
    if (cond_bit_out !== 3'b010) begin
      errors++; $display("FAIL pc_cond got=%b exp=010", cond_bit_out);
    end
  endtask

  task automatic test_copy();
    bit done_seen = 0;
    for (int i = 1; i < 16; i++) wr(0, i, 16'(i * 16'h11));
    copy_src = 1'b0; copy_dst = 1'b1; copy_start = 1'b1;
    tick();   // accepting edge T
    copy_start = 1'b0;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      checks++;
      if (copy_busy !== (k < 15)) begin
        errors++; $display("FAIL copy_busy_k%0d got=%b exp=%b", k, copy_busy, k < 15);
      end
      checks++;
      if (copy_done !== (k == 15)) begin
        errors++; $display("FAIL copy_done_k%0d got=%b exp=%b", k, copy_done, k == 15);
      end
      if (copy_done) done_seen = 1;
      write_en = 1'b0; copy_start = 1'b0;
      if (k == 4) begin   // idx==5: core write collides with the copy write
        active_bank = 1'b1; write_register_num = 4'd5;
        write_register_in = 16'hBEEF; write_en = 1'b1;
      end
      if (k == 8) begin   // ignored while busy
        copy_src = 1'b1; copy_dst = 1'b0; copy_start = 1'b1;
      end
      if (!done_seen) tick();
    end
    write_en = 1'b0; copy_start = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL copy_done_timeout got=0 exp=1");
    end
    for (int r = 0; r < 16; r++) model[1][r] = model[0][r];
    model[1][5] = 16'hBEEF;
    mflag[1] = mflag[0];
    read_all_banks("copy");
  endtask

  task automatic test_same_bank();
    copy_src = 1'b1; copy_dst = 1'b1; copy_start = 1'b1;
    tick();
    copy_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (copy_busy !== 1'b0 || copy_done !== 1'b0) begin
        errors++; $display("FAIL same_bank_k%0d got=%b%b exp=00", k, copy_busy, copy_done);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_copy();
    bit done_seen = 0;
    copy_src = 1'b0; copy_dst = 1'b1; copy_start = 1'b1;
    tick();
    copy_start = 1'b0;
    for (int k = 0; k < 6; k++) tick();  // now in busy cycle 7
    checks++;
    if (copy_busy !== 1'b1) begin
      errors++; $display("FAIL mid_copy_busy got=%b exp=1", copy_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (copy_busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy got=%b exp=0", copy_busy);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (copy_done) done_seen = 1;
      tick();
    end
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL abort_done_pulse got=1 exp=0");
    end
    model_clear();
    read_all_banks("abort");
  endtask

  initial begin
    test_reset();
    test_write();
    test_r0_pc();
    test_copy();
    test_same_bank();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banked_register_file.md
# banked_register_file

Parametrised multi-bank register file for the Retro16 core. It generalises the fixed 16x16, 2-bank file: data width, register count, bank count and PC index are parameters, and condition flags are stored per bank. A sequential bank-copy engine duplicates one bank into another for context switching. It sits between decode (read ports), writeback (write port) and fetch (PC port).

## Interface
- DATA_W, 16, register width in bits (≥2).
- NUM_REGS, 16, registers per bank; power of two, ≥4.
- NUM_BANKS, 2, number of banks; power of two, ≥2.
- PC_INDEX, 6, register index used as PC; 1 ≤ PC_INDEX < NUM_REGS.
- Derived: RW = clog2(NUM_REGS), BW = clog2(NUM_BANKS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- active_bank  in  BW  bank used by all read, write and PC ports.
- left_register_num / right_register_num  in  RW  read port A/B indices.
- left_register_out / right_register_out  out  DATA_W  read data, combinational.
- write_register_num  in  RW  write index.
- write_register_in  in  DATA_W  write data.
- write_en  in  1  write strobe.
- pc_register_in  in  DATA_W  PC write data.
- pc_write_en  in  1  PC write strobe.
- pc_register_out  out  DATA_W  PC of active bank, combinational.
- cond_bit_out  out  3  {zero, positive, negative} flags of active bank.
- copy_start  in  1  request bank copy (single-cycle pulse).
- copy_src / copy_dst  in  BW  source/destination banks; sampled on the accepted copy_start.
- copy_busy  out  1  copy in progress.
- copy_done  out  1  one-cycle completion pulse.

## Operation
- Register 0 of every bank reads 0. Writes to register 0 do not change storage but still update flags.
- Write: when write_en=1, the file stores active_bank[write_register_num] ← write_register_in. It also stores flags[active_bank] ← {data==0, data[MSB]==0 && data!=0, data[MSB]}.
- PC: when pc_write_en=1, the file stores active_bank[PC_INDEX] ← pc_register_in. If write_en targets PC_INDEX in the same cycle, pc_write_en wins. Flags are still updated from write_register_in.
- Reads: storage of active_bank, indexed combinationally. Forwarding is controlled by the Configuration section.
- Copy FSM states:
  - IDLE: copy_start with copy_src≠copy_dst latches src/dst, sets idx=1 and goes to COPY. copy_start with src==dst is ignored.
  - COPY: each cycle writes dst[idx] ← src[idx] using pre-edge stored values, then idx+1. At idx=NUM_REGS-1 it also copies flags[src]→flags[dst] and returns to IDLE.
  - copy_start during COPY is ignored.
- Collisions: in the same cycle, a core write or PC write to the same bank and register as the copy write wins over the copy write. Core writes to the source bank during a copy are allowed. Registers already copied keep their old value in the destination.
- Core flag update to the dst bank in the final COPY cycle wins over the flag copy.

## Timing
- Reset (async assert, sync release): all registers and flags 0, FSM IDLE, idx 0, copy_busy=0, copy_done=0. Read, PC and cond outputs are therefore 0.
- Write latency: storage visible to reads the cycle after write_en, without bypass. cond_bit_out updates the cycle after write_en and is never forwarded.
- Copy: copy_start accepted at edge T. copy_busy is high for cycles T+1 … T+NUM_REGS-1 (NUM_REGS-1 cycles). copy_done is high for cycle T+NUM_REGS only. Destination is fully valid from T+NUM_REGS.
- rst_n asserted mid-copy aborts immediately. copy_done does not pulse. Both banks are cleared.
- A new copy may be accepted in the same cycle copy_done is high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - left/right outputs return write_register_in when write_en=1, the index matches and the index is nonzero.
  - pc_register_out returns pc_register_in when pc_write_en=1, else write_register_in when write_en targets PC_INDEX, else storage.
- REGFILE_BYPASS_EN undefined: all read and PC outputs come from storage only. Writes become visible one cycle later.

## Test plan
- Reset then read r1..r15 of every bank → all 0; cond_bit_out=3'b000; copy_busy=0.
- Write r3=16'h8001 (bank 0) → next cycle reads 16'h8001 and cond=3'b001. With bypass, the same cycle also reads 16'h8001. Without bypass, the same cycle reads 0.
- Write r0=16'h0000 → r0 still reads 0, cond=3'b100. Same cycle: pc_write_en with 16'h0100 and write_en to r6 with 16'h0200 → next cycle PC=16'h0100.
- Fill bank 0 with r[i]=i*16'h11, copy_start src=0 dst=1 at T → busy for 15 cycles, done pulse at T+16, bank 1 matches bank 0 including flags.
- During the copy above, core writes bank 1 r5=16'hBEEF in the cycle idx=5 → r5 ends 16'hBEEF. copy_start with src==dst → ignored, no busy.
- Assert rst_n low at busy cycle 7 → copy_done never pulses; all registers read 0 after release.
